// File: rtl/icache.sv
// Direct-mapped instruction cache, one 32-bit word per line, refilled a byte
// at a time from the memory controller. Hits answer in the same cycle; misses
// walk IDLE -> REFILL -> RESP.
// Optional feature macro: ICACHE_EN. When undefined, no storage is built and
// every fetch takes the refill path.
module icache #(
  parameter int INDEX_BITS = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req_in,
  input  logic [31:0] inst_addr_in,
  output logic        inst_valid_out,
  output logic [31:0] inst_out,
  output logic        mem_req_out,
  output logic [31:0] mem_addr_out,
  input  logic        mem_valid_in,
  input  logic [7:0]  mem_data_in
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 32 - INDEX_BITS - 2;

  typedef enum logic [1:0] {IDLE, REFILL, RESP} state_t;

  state_t      state_q;
  logic [1:0]  cnt_q;
  logic [31:0] base_q;
  logic [31:0] word_q;

  logic        hit;
  logic [31:0] hit_data;
  logic        line_wr;
  logic [31:0] aligned_addr;

  assign aligned_addr = inst_addr_in & 32'hFFFF_FFFC;
  // The line is committed in the same cycle the last byte arrives.
  assign line_wr = (state_q == REFILL) && mem_valid_in && (cnt_q == 2'd3);

`ifdef ICACHE_EN
  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  logic [INDEX_BITS-1:0] rd_idx;
  logic [INDEX_BITS-1:0] wr_idx;

  assign rd_idx   = inst_addr_in[INDEX_BITS+1:2];
  assign wr_idx   = base_q[INDEX_BITS+1:2];
  assign hit      = valid_q[rd_idx] && (tag_q[rd_idx] == inst_addr_in[31:INDEX_BITS+2]);
  assign hit_data = data_q[rd_idx];

  // Valid bits are the only storage that must be cleared on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (line_wr) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag and data arrays are written once per completed refill.
  always_ff @(posedge clk) begin
    if (line_wr) begin
      tag_q[wr_idx]  <= base_q[31:INDEX_BITS+2];
      data_q[wr_idx] <= {mem_data_in, word_q[23:0]};
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  // Control FSM: a refill always runs to completion once started.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (inst_req_in && !hit) begin
            state_q <= REFILL;
            cnt_q   <= 2'd0;
          end
        end
        REFILL: begin
          if (mem_valid_in) begin
            cnt_q <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) state_q <= RESP;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Refill datapath: latch the aligned miss address and assemble bytes.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && inst_req_in && !hit) begin
      base_q <= aligned_addr;
    end
    if (state_q == REFILL && mem_valid_in) begin
      word_q[{cnt_q, 3'b000} +: 8] <= mem_data_in;
    end
  end

  // Output decode; RESP only answers if IF still wants the refilled word.
  always_comb begin
    inst_valid_out = 1'b0;
    inst_out       = '0;
    mem_req_out    = 1'b0;
    mem_addr_out   = '0;
    case (state_q)
      IDLE: begin
        if (inst_req_in && hit) begin
          inst_valid_out = 1'b1;
          inst_out       = hit_data;
        end
      end
      REFILL: begin
        mem_req_out  = 1'b1;
        mem_addr_out = base_q + {30'd0, cnt_q};
      end
      RESP: begin
        if (inst_req_in && (aligned_addr == base_q)) begin
          inst_valid_out = 1'b1;
          inst_out       = word_q;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: refill timing, hits, eviction, memory stalls,
// redirect during refill and reset during refill.
module tb_icache;

`ifdef ICACHE_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        inst_req_in;
  logic [31:0] inst_addr_in;
  logic        inst_valid_out;
  logic [31:0] inst_out;
  logic        mem_req_out;
  logic [31:0] mem_addr_out;
  logic        mem_valid_in;
  logic [7:0]  mem_data_in;

  logic        mem_en;
  logic [7:0]  mem [1024];

  int tests = 0;
  int fails = 0;

  icache #(.INDEX_BITS(7)) dut (
    .clk            (clk),
    .rst            (rst),
    .inst_req_in    (inst_req_in),
    .inst_addr_in   (inst_addr_in),
    .inst_valid_out (inst_valid_out),
    .inst_out       (inst_out),
    .mem_req_out    (mem_req_out),
    .mem_addr_out   (mem_addr_out),
    .mem_valid_in   (mem_valid_in),
    .mem_data_in    (mem_data_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte-wide memory: answers whatever address the cache presents.
  assign mem_valid_in = mem_en && mem_req_out;
  assign mem_data_in  = mem[mem_addr_out[9:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, {31'd0, inst_valid_out}, 32'd0);
    chk({tag, "_inst"},  inst_out, 32'd0);
    chk({tag, "_mreq"},  {31'd0, mem_req_out}, 32'd0);
    chk({tag, "_maddr"}, mem_addr_out, 32'd0);
  endtask

  // Issue a fetch and follow it to its answer. stall_k/stall_n hold
  // mem_valid_in low for stall_n cycles while byte stall_k is pending.
  task automatic fetch(input string tag, input logic [31:0] a, input bit hit,
                       input logic [31:0] w, input int stall_k, input int stall_n);
    logic [31:0] base;
    base         = a & 32'hFFFF_FFFC;
    inst_req_in  = 1'b1;
    inst_addr_in = a;
    mem_en       = 1'b1;
    #1;
    chk({tag, "_c0_valid"}, {31'd0, inst_valid_out}, {31'd0, hit});
    chk({tag, "_c0_inst"},  inst_out, hit ? w : 32'd0);
    chk({tag, "_c0_mreq"},  {31'd0, mem_req_out}, 32'd0);
    if (!hit) begin
      for (int k = 0; k < 4; k++) begin
        @(posedge clk); #2;
        if (k == stall_k) begin
          mem_en = 1'b0;
          for (int s = 0; s < stall_n; s++) begin
            #1 chk({tag, "_stall_addr"}, mem_addr_out, base + k);
            @(posedge clk); #2;
          end
          mem_en = 1'b1;
        end
        #1;
        chk({tag, "_ref_mreq"},  {31'd0, mem_req_out}, 32'd1);
        chk({tag, "_ref_addr"},  mem_addr_out, base + k);
        chk({tag, "_ref_valid"}, {31'd0, inst_valid_out}, 32'd0);
      end
      @(posedge clk); #3;
      chk({tag, "_resp_valid"}, {31'd0, inst_valid_out}, 32'd1);
      chk({tag, "_resp_inst"},  inst_out, w);
      chk({tag, "_resp_mreq"},  {31'd0, mem_req_out}, 32'd0);
    end
    @(posedge clk); #2;
    inst_req_in = 1'b0;
    #1 chk_idle({tag, "_after"});
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[10'h004] = 8'h13; mem[10'h005] = 8'h05; mem[10'h006] = 8'h10; mem[10'h007] = 8'h00;
    mem[10'h204] = 8'h93; mem[10'h205] = 8'h00; mem[10'h206] = 8'h10; mem[10'h207] = 8'h00;
    mem[10'h080] = 8'h6f; mem[10'h081] = 8'h00; mem[10'h082] = 8'h00; mem[10'h083] = 8'h00;
    mem[10'h010] = 8'hb7; mem[10'h011] = 8'h12; mem[10'h012] = 8'h34; mem[10'h013] = 8'h56;
    mem[10'h040] = 8'h01; mem[10'h041] = 8'h02; mem[10'h042] = 8'h03; mem[10'h043] = 8'h04;
    mem[10'h020] = 8'haa; mem[10'h021] = 8'hbb; mem[10'h022] = 8'hcc; mem[10'h023] = 8'hdd;

    rst          = 1'b1;
    inst_req_in  = 1'b1;
    inst_addr_in = 32'h0000_0004;
    mem_en       = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_idle("reset");
    #1 rst = 1'b0;

    // Cold miss, then a same-line hit at a different byte offset.
    fetch("miss4",   32'h0000_0004, 1'b0, 32'h0010_0513, -1, 0);
    fetch("hit6",    32'h0000_0006, EN,   32'h0010_0513, -1, 0);
    // Same index, different tag: evicts 0x4.
    fetch("miss204", 32'h0000_0204, 1'b0, 32'h0010_0093, -1, 0);
    fetch("evict4",  32'h0000_0004, 1'b0, 32'h0010_0513, -1, 0);
    fetch("hit204x", 32'h0000_0004, EN,   32'h0010_0513, -1, 0);
    // Memory stall of 3 cycles while byte 1 is pending.
    fetch("stall80", 32'h0000_0080, 1'b0, 32'h0000_006f, 1, 3);
    fetch("hit80",   32'h0000_0080, EN,   32'h0000_006f, -1, 0);

    // Redirect from 0x10 to 0x40 in the middle of the 0x10 refill.
    inst_req_in  = 1'b1;
    inst_addr_in = 32'h0000_0010;
    #1 chk("redir_c0_valid", {31'd0, inst_valid_out}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #2;
      if (k == 2) inst_addr_in = 32'h0000_0040;
      #1 chk("redir_ref_addr", mem_addr_out, 32'h0000_0010 + k);
    end
    @(posedge clk); #3;
    chk("redir_resp_valid", {31'd0, inst_valid_out}, 32'd0);
    chk("redir_resp_inst",  inst_out, 32'd0);
    chk("redir_resp_mreq",  {31'd0, mem_req_out}, 32'd0);
    @(posedge clk); #2;
    fetch("miss40", 32'h0000_0040, 1'b0, 32'h0403_0201, -1, 0);
    fetch("hit10",  32'h0000_0010, EN,   32'h5634_12b7, -1, 0);

    // Reset while the byte counter sits at 2.
    inst_req_in  = 1'b1;
    inst_addr_in = 32'h0000_0020;
    for (int k = 0; k < 3; k++) @(posedge clk);
    #2 chk("rst_pre_addr", mem_addr_out, 32'h0000_0022);
    rst = 1'b1;
    #1 chk_idle("rst_mid");
    @(posedge clk); #1 chk_idle("rst_hold");
    #1 rst = 1'b0;
    fetch("refill20", 32'h0000_0020, 1'b0, 32'hddcc_bbaa, -1, 0);
    // Valid bits were cleared, so 0x4 must refill again.
    fetch("post_rst4", 32'h0000_0004, 1'b0, 32'h0010_0513, -1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
